// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   state_e       : clear-sweep / run FSM encoding
//   XLEN_DEF      : default data width
//   NREGS_DEF     : default register count
//   MAX_WR        : widest write-port match vector the helpers accept
//   hi_match_idx  : index of the highest set bit of a write-port match vector
package regfile_pkg;

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned MAX_WR    = 3;

    // Highest-index write port wins, both for array updates and for bypass.
    function automatic logic [1:0] hi_match_idx(input logic [MAX_WR-1:0] match);
        logic [1:0] idx;
        idx = '0;
        for (int j = 0; j < MAX_WR; j++) begin
            if (match[j]) idx = 2'(j);
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits used for RAW hazard detection.
//   clk_i        : rising-edge clock
//   rst_i        : synchronous active-high reset, clears every pending bit
//   en_i         : register file ready; writes and allocs ignored while low
//   wr_en_i      : per write port enable (clears the addressed bit)
//   wr_addr_i    : write addresses, port j at [j*AW +: AW]
//   alloc_en_i   : mark alloc_addr_i pending (wins over a same-cycle write)
//   alloc_addr_i : destination being allocated
//   rd_addr_i    : lookup addresses, port i at [i*AW +: AW]
//   rd_pending_o : lookup results, cleared by a bypassed same-cycle write
module regfile_scoreboard #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NWR      = 1,
    parameter int unsigned NRD      = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD-1:0]    rd_pending_o
);

    logic [NREGS-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (en_i) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j]) pending_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
            // Applied after the clears: a new producer supersedes the retiring one.
            if (alloc_en_i) pending_d[alloc_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        logic [AW-1:0] ra;
        logic          hit;
        assign ra = rd_addr_i[i*AW +: AW];

        always_comb begin
            hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == ra)) hit = 1'b1;
            end
        end

        assign rd_pending_o[i] = en_i && pending_q[ra] && !((BYPASS != 0) && hit)
                                 && !((ZERO_REG != 0) && (ra == '0));
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with write-to-read bypass,
// post-reset clear sweep and a pending scoreboard.
//   clk_i        : rising-edge clock
//   rst_i        : synchronous active-high reset; restarts the clear sweep
//   ready_o      : high once every register has been cleared
//   rd_addr_i    : read addresses, port i at [i*AW +: AW]
//   rd_data_o    : combinational read data, port i at [i*XLEN +: XLEN]
//   rd_pending_o : port i's register awaits writeback
//   wr_en_i      : per write port enable
//   wr_addr_i    : write addresses, port j at [j*AW +: AW]
//   wr_data_i    : write data, port j at [j*XLEN +: XLEN]
//   alloc_en_i   : mark alloc_addr_i pending
//   alloc_addr_i : destination register to mark
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                ready_o,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_pending_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                alloc_en_i,
    input  logic [AW-1:0]       alloc_addr_i
);

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          ready_q, ready_d;
    logic [XLEN-1:0] regs_q [NREGS];

    // Clear-sweep FSM.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        unique case (state_q)
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LastIdx) begin
                    state_d = StRun;
                    ready_d = 1'b1;
                end
            end
            StRun: ;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // Storage is not reset directly; the sweep zeroes it one entry per cycle.
    // Ascending port order makes the highest-index port win on collisions.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == StClear) begin
                regs_q[clr_idx_q] <= '0;
            end else if (ready_q) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && !((ZERO_REG != 0) && (wr_addr_i[j*AW +: AW] == '0))) begin
                        regs_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [MAX_WR-1:0] match;
        logic [XLEN-1:0]   data;
        assign ra = rd_addr_i[i*AW +: AW];

        always_comb begin
            match = '0;
            for (int j = 0; j < NWR; j++) begin
                match[j] = wr_en_i[j] && (wr_addr_i[j*AW +: AW] == ra);
            end
            data = regs_q[ra];
            if ((BYPASS != 0) && (|match)) begin
                data = wr_data_i[int'(hi_match_idx(match))*XLEN +: XLEN];
            end
            if (((ZERO_REG != 0) && (ra == '0)) || !ready_q) data = '0;
        end

        assign rd_data_o[i*XLEN +: XLEN] = data;
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .NRD      (NRD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (ready_q),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .rd_addr_i    (rd_addr_i),
        .rd_pending_o (rd_pending_o)
    );

    assign ready_o = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing DUT and a non-bypassing DUT share all stimulus.
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NWR-1:0]      wr_en_i;
    logic [NWR*AW-1:0]   wr_addr_i;
    logic [NWR*XLEN-1:0] wr_data_i;
    logic                alloc_en_i;
    logic [AW-1:0]       alloc_addr_i;

    logic                ready_o, ready_nb;
    logic [NRD*XLEN-1:0] rd_data_o, rd_data_nb;
    logic [NRD-1:0]      rd_pending_o, rd_pending_nb;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    always #5 clk_i = ~clk_i;

    regfile_mp #(
        .XLEN (XLEN), .NREGS (NREGS), .NRD (NRD), .NWR (NWR), .BYPASS (1), .ZERO_REG (1)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ready_o      (ready_o),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_pending_o (rd_pending_o),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i)
    );

    regfile_mp #(
        .XLEN (XLEN), .NREGS (NREGS), .NRD (NRD), .NWR (NWR), .BYPASS (0), .ZERO_REG (1)
    ) u_dut_nb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ready_o      (ready_nb),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_nb),
        .rd_pending_o (rd_pending_nb),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en_i    = '0;
        alloc_en_i = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en_i[p]               = 1'b1;
        wr_addr_i[p*AW +: AW]    = a;
        wr_data_i[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr_i = {a1, a0};
        #1;
    endtask

    // Counts posedges from reset deassert until ready rises, with writes and
    // allocs held asserted the whole time to show they are ignored.
    task automatic sweep_count(output int n);
        n = 0;
        set_wr(0, 5'd5, 32'hFFFF_0005);
        set_wr(1, 5'd6, 32'hFFFF_0006);
        alloc_en_i   = 1'b1;
        alloc_addr_i = 5'd6;
        while (!ready_o && n < 40) begin
            tick();
            n++;
        end
        idle();
        #1;
    endtask

    initial begin
        rst_i        = 1'b1;
        rd_addr_i    = '0;
        wr_addr_i    = '0;
        wr_data_i    = '0;
        alloc_addr_i = '0;
        idle();
        repeat (3) tick();
        check("reset_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b0;
        set_rd(5'd5, 5'd6);
        check("clear_rd_data", rd_data_o[31:0], 32'd0);
        sweep_count(cyc);
        check("sweep_latency", cyc, 32'd32);

        // Restart the sweep from index 10.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        repeat (10) tick();
        check("mid_sweep_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sweep_count(cyc);
        check("restart_latency", cyc, 32'd32);
        check("nb_ready", 32'(ready_nb), 32'd1);

        for (int r = 0; r < 16; r++) begin
            set_rd(AW'(r), AW'(r + 16));
            check($sformatf("zero_x%0d", r), rd_data_o[31:0], 32'd0);
            check($sformatf("zero_x%0d", r + 16), rd_data_o[63:32], 32'd0);
            check($sformatf("pend_x%0d", r), 32'(rd_pending_o), 32'd0);
        end

        // Write/read and zero register.
        set_wr(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        set_wr(0, 5'd0, 32'h0000_1234);
        tick();
        idle();
        set_rd(5'd5, 5'd0);
        check("x5_data", rd_data_o[31:0], 32'hDEAD_BEEF);
        check("x0_data", rd_data_o[63:32], 32'd0);

        // Two-port write collision with bypass.
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        set_rd(5'd7, 5'd5);
        check("bypass_hi_port", rd_data_o[31:0], 32'h22);
        check("nobypass_old", rd_data_nb[31:0], 32'd0);
        check("bypass_other_port", rd_data_o[63:32], 32'hDEAD_BEEF);
        tick();
        idle();
        #1;
        check("x7_array", rd_data_o[31:0], 32'h22);
        check("x7_array_nb", rd_data_nb[31:0], 32'h22);

        // Scoreboard: alloc then bypassed writeback.
        alloc_en_i   = 1'b1;
        alloc_addr_i = 5'd9;
        tick();
        idle();
        set_rd(5'd9, 5'd7);
        check("x9_pending", 32'(rd_pending_o), 32'b01);
        set_wr(1, 5'd9, 32'h55);
        #1;
        check("x9_bypass_pend", 32'(rd_pending_o), 32'b00);
        check("x9_bypass_data", rd_data_o[31:0], 32'h55);
        check("x9_nb_pend", 32'(rd_pending_nb), 32'b01);
        check("x9_nb_data", rd_data_nb[31:0], 32'd0);
        tick();
        idle();
        #1;
        check("x9_after_pend", 32'(rd_pending_o), 32'b00);
        check("x9_after_data", rd_data_o[31:0], 32'h55);

        // Alloc and write to the same register in one cycle.
        alloc_en_i   = 1'b1;
        alloc_addr_i = 5'd3;
        set_wr(0, 5'd3, 32'h77);
        tick();
        idle();
        set_rd(5'd3, 5'd9);
        check("x3_data", rd_data_o[31:0], 32'h77);
        check("x3_pending", 32'(rd_pending_o), 32'b01);

        // Alloc of x0 never marks it pending.
        alloc_en_i   = 1'b1;
        alloc_addr_i = 5'd0;
        tick();
        idle();
        set_rd(5'd0, 5'd3);
        check("x0_pending", 32'(rd_pending_o), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the 2R/1W pipeline register file.
- Adds configurable width, depth, read-port and write-port counts, and same-cycle write-to-read bypass.
- Adds a hardware clear sweep after reset and a per-register pending scoreboard for hazard detection.
- Sits between decode (reads, alloc) and writeback (write ports) in the core pipeline.

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of registers; power of two, ≥ 4.
- AW, $clog2(NREGS), register address width; derived, never overridden.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..3.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never pending.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sweep is done; writes and allocs are accepted only when high.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_pending  out  NRD  port i's register awaits writeback.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  1  mark a destination register pending.
- alloc_addr  in  AW  destination register to mark.

Behaviour:
- FSM states: CLEAR, RUN (encoding in package).
- Reset:
  - While rst=1 at a posedge: state<=CLEAR, clr_idx<=0, all pending bits<=0, ready<=0.
  - rst overrides everything; asserting it mid-sweep restarts the sweep from index 0.
- CLEAR sweep:
  - Each posedge with rst=0: regs[clr_idx]<=0, clr_idx<=clr_idx+1.
  - The posedge that clears index NREGS-1 sets state<=RUN, ready<=1.
  - ready therefore rises exactly NREGS cycles after rst deasserts.
- While ready=0:
  - rd_data all zero; rd_pending all zero.
  - wr_en and alloc_en are ignored, with no state change.
- Write (RUN):
  - At posedge, for each port j with wr_en[j]=1: regs[wr_addr[j]]<=wr_data[j] and pending[wr_addr[j]]<=0.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Two ports to the same address: the highest-index port wins.
- Read (combinational, zero latency):
  - Address 0 with ZERO_REG=1 returns 0.
  - Else, with BYPASS=1, the data of the highest-index write port with wr_en=1 and a matching address is returned.
  - Else the array value is returned.
  - With BYPASS=0, same-cycle writes are visible only from the next cycle.
- Scoreboard:
  - alloc_en=1 at posedge sets pending[alloc_addr]<=1; ignored for address 0 when ZERO_REG=1.
  - Same-cycle alloc and write to the same address: alloc wins, so the bit ends at 1 (new producer).
  - rd_pending[i] = pending[rd_addr[i]], cleared if a same-cycle write to that address is bypassed.
  - rd_pending[i] is 0 for address 0 when ZERO_REG=1.
- Out-of-range addresses cannot occur: the address width equals log2(NREGS).

Decomposition:
- regfile_pkg holds:
  - FSM state enum {CLEAR, RUN}.
  - Default constants XLEN_DEF=32 and NREGS_DEF=32.
  - A function for bypass priority select (highest-index match).
- Sub-module regfile_scoreboard(NREGS, NWR) holds:
  - the pending bit vector,
  - set/clear priority logic,
  - per-port lookup outputs.
- Storage, bypass mux and clear FSM stay in regfile_mp.

Test Plan:
- Reset/sweep: rst high 3 cycles then low, NREGS=32 → ready=0 for 32 cycles, rises on the 32nd posedge; every register then reads 0. Repeat with rst pulsed at sweep index 10 → ready delayed a full 32 cycles from the new deassert.
- Write/read and zero reg: write 0xDEADBEEF to x5, then 0x1234 to x0 → next cycle x5 reads 0xDEADBEEF, x0 reads 0.
- Bypass, NWR=2: same cycle, port0 writes x7=0x11, port1 writes x7=0x22, rd_addr0=7 → rd_data0=0x22 combinationally; next cycle array x7=0x22. With BYPASS=0 → same-cycle read returns the old value.
- Scoreboard: alloc x9 → next cycle rd_pending=1 for x9. Write x9=0x55 → same cycle rd_pending=0 with data 0x55 bypassed; bit clear afterwards.
- Alloc/write collision: alloc x3 and write x3=0x77 in the same cycle → x3=0x77, pending[x3]=1 next cycle.
- Gating: wr_en and alloc_en asserted during CLEAR → no effect; after ready, registers are 0 and no pending bits are set.
